// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode, the write-back/memory stages and the ID/EX operand stage.
// The stage itself connects through the slave modport.
interface id_ex_operand_stage_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 17,
  parameter int RA_W   = 5
);
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [RA_W-1:0]   id_rs1;
  logic [RA_W-1:0]   id_rs2;
  logic              id_uses_rs2;
  logic [RA_W-1:0]   id_rd;
  logic [CTRL_W-1:0] id_control_ALU;
  logic              id_use_imm;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              flush;
  logic [RA_W-1:0]   mem_rd;
  logic              mem_reg_write;
  logic [XLEN-1:0]   mem_result;
  logic [RA_W-1:0]   wb_rd;
  logic              wb_reg_write;
  logic [XLEN-1:0]   wb_result;
  logic [XLEN-1:0]   x1;
  logic [XLEN-1:0]   x2;
  logic [CTRL_W-1:0] control_ALU;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [XLEN-1:0]   ex_store_data;
  logic              stall_id;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_uses_rs2, id_rd, id_control_ALU, id_use_imm, id_reg_write,
           id_mem_read, id_mem_write, flush, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    input  x1, x2, control_ALU, ex_valid, ex_pc, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, stall_id
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_uses_rs2, id_rd, id_control_ALU, id_use_imm, id_reg_write,
           id_mem_read, id_mem_write, flush, mem_rd, mem_reg_write, mem_result,
           wb_rd, wb_reg_write, wb_result,
    output x1, x2, control_ALU, ex_valid, ex_pc, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data, stall_id
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with WB capture bypass, EX-side MEM/WB forwarding
// and load-use stall / flush bubble insertion.
module id_ex_operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 17,
  parameter int RA_W   = 5
) (
  input logic                  clk,
  input logic                  rst,
  id_ex_operand_stage_if.slave bus
);

  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   rs1_val_p1;
  logic [XLEN-1:0]   rs2_val_p1;
  logic [XLEN-1:0]   imm_p1;
  logic [RA_W-1:0]   rs1_p1;
  logic [RA_W-1:0]   rs2_p1;
  logic [RA_W-1:0]   rd_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic              use_imm_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;

  logic              hz;
  logic              load;
  logic [XLEN-1:0]   fwd1;
  logic [XLEN-1:0]   fwd2;

  // A write to x0 never reaches a consumer, so rd==0 is excluded from every match.
  function automatic logic [XLEN-1:0] wb_bypass(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] base,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_dst,
    input logic [XLEN-1:0] wb_val
  );
    if (wb_we && (wb_dst != '0) && (wb_dst == rs)) return wb_val;
    return base;
  endfunction

  function automatic logic [XLEN-1:0] ex_forward(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] base,
    input logic            mem_we,
    input logic [RA_W-1:0] mem_dst,
    input logic [XLEN-1:0] mem_val,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_dst,
    input logic [XLEN-1:0] wb_val
  );
    if (mem_we && (mem_dst != '0) && (mem_dst == rs)) return mem_val;
    return wb_bypass(rs, base, wb_we, wb_dst, wb_val);
  endfunction

  assign hz = bus.id_valid && vld_p1 && mem_read_p1 && (rd_p1 != '0) &&
              ((rd_p1 == bus.id_rs1) || (bus.id_uses_rs2 && (rd_p1 == bus.id_rs2)));
  assign load = bus.id_valid && !bus.flush && !hz;
  assign bus.stall_id = hz && !bus.flush;

  // ID -> EX boundary: bubbles (reset, flush, hazard, empty ID) clear every field.
  always_ff @(posedge clk) begin
    if (rst || !load) begin
      vld_p1       <= 1'b0;
      pc_p1        <= '0;
      rs1_val_p1   <= '0;
      rs2_val_p1   <= '0;
      imm_p1       <= '0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rd_p1        <= '0;
      ctrl_p1      <= '0;
      use_imm_p1   <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else begin
      vld_p1       <= 1'b1;
      pc_p1        <= bus.id_pc;
      rs1_val_p1   <= wb_bypass(bus.id_rs1, bus.id_rs1_data, bus.wb_reg_write,
                                bus.wb_rd, bus.wb_result);
      rs2_val_p1   <= wb_bypass(bus.id_rs2, bus.id_rs2_data, bus.wb_reg_write,
                                bus.wb_rd, bus.wb_result);
      imm_p1       <= bus.id_imm;
      rs1_p1       <= bus.id_rs1;
      rs2_p1       <= bus.id_rs2;
      rd_p1        <= bus.id_rd;
      ctrl_p1      <= bus.id_control_ALU;
      use_imm_p1   <= bus.id_use_imm;
      reg_write_p1 <= bus.id_reg_write;
      mem_read_p1  <= bus.id_mem_read;
      mem_write_p1 <= bus.id_mem_write;
    end
  end

  // EX operand resolution against the instructions now in MEM and WB.
  assign fwd1 = ex_forward(rs1_p1, rs1_val_p1, bus.mem_reg_write, bus.mem_rd,
                           bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  assign fwd2 = ex_forward(rs2_p1, rs2_val_p1, bus.mem_reg_write, bus.mem_rd,
                           bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);

  assign bus.x1            = vld_p1 ? fwd1 : '0;
  assign bus.x2            = vld_p1 ? (use_imm_p1 ? imm_p1 : fwd2) : '0;
  assign bus.ex_store_data = vld_p1 ? fwd2 : '0;
  assign bus.control_ALU   = vld_p1 ? ctrl_p1 : '0;
  assign bus.ex_valid      = vld_p1;
  assign bus.ex_pc         = pc_p1;
  assign bus.ex_rd         = rd_p1;
  assign bus.ex_reg_write  = vld_p1 && reg_write_p1;
  assign bus.ex_mem_read   = vld_p1 && mem_read_p1;
  assign bus.ex_mem_write  = vld_p1 && mem_write_p1;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed table-driven bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_operand_stage_if bus ();
  id_ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        v;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        uses, use_imm, rw, mr, mw;
    logic [16:0] ctrl;
  } id_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
  } fw_t;

  typedef struct {
    logic        stall, valid, rw, mr, mw;
    logic [31:0] x1, x2, sd, pc;
    logic [16:0] ctrl;
    logic [4:0]  rd;
  } exp_t;

  typedef struct {
    id_t  id;
    logic flush;
    fw_t  cwb;
    fw_t  omem;
    fw_t  owb;
    exp_t e;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic id_t instr(logic v, logic [31:0] pc, logic [4:0] rs1, logic [31:0] rs1d,
                                logic [4:0] rs2, logic [31:0] rs2d, logic uses, logic [31:0] imm,
                                logic use_imm, logic [4:0] rd, logic [16:0] ctrl,
                                logic rw, logic mr, logic mw);
    id_t r;
    r.v = v; r.pc = pc; r.rs1 = rs1; r.rs1d = rs1d; r.rs2 = rs2; r.rs2d = rs2d;
    r.uses = uses; r.imm = imm; r.use_imm = use_imm; r.rd = rd; r.ctrl = ctrl;
    r.rw = rw; r.mr = mr; r.mw = mw;
    return r;
  endfunction

  function automatic fw_t fw(logic we, logic [4:0] rd, logic [31:0] res);
    fw_t r;
    r.we = we; r.rd = rd; r.res = res;
    return r;
  endfunction

  function automatic exp_t ex(logic stall, logic valid, logic [31:0] x1, logic [31:0] x2,
                              logic [31:0] sd, logic [16:0] ctrl, logic [4:0] rd,
                              logic [31:0] pc, logic rw, logic mr, logic mw);
    exp_t r;
    r.stall = stall; r.valid = valid; r.x1 = x1; r.x2 = x2; r.sd = sd; r.ctrl = ctrl;
    r.rd = rd; r.pc = pc; r.rw = rw; r.mr = mr; r.mw = mw;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic drive_id(input id_t d, input logic fl);
    bus.id_valid       = d.v;
    bus.id_pc          = d.pc;
    bus.id_rs1_data    = d.rs1d;
    bus.id_rs2_data    = d.rs2d;
    bus.id_imm         = d.imm;
    bus.id_rs1         = d.rs1;
    bus.id_rs2         = d.rs2;
    bus.id_uses_rs2    = d.uses;
    bus.id_rd          = d.rd;
    bus.id_control_ALU = d.ctrl;
    bus.id_use_imm     = d.use_imm;
    bus.id_reg_write   = d.rw;
    bus.id_mem_read    = d.mr;
    bus.id_mem_write   = d.mw;
    bus.flush          = fl;
  endtask

  task automatic drive_fw(input fw_t m, input fw_t w);
    bus.mem_reg_write = m.we;
    bus.mem_rd        = m.rd;
    bus.mem_result    = m.res;
    bus.wb_reg_write  = w.we;
    bus.wb_rd         = w.rd;
    bus.wb_result     = w.res;
  endtask

  task automatic chk_ex(input string tag, input exp_t e);
    chk({tag, " ex_valid"},     {31'd0, bus.ex_valid},     {31'd0, e.valid});
    chk({tag, " x1"},           bus.x1,                    e.x1);
    chk({tag, " x2"},           bus.x2,                    e.x2);
    chk({tag, " store_data"},   bus.ex_store_data,         e.sd);
    chk({tag, " control_ALU"},  {15'd0, bus.control_ALU},  {15'd0, e.ctrl});
    chk({tag, " ex_rd"},        {27'd0, bus.ex_rd},        {27'd0, e.rd});
    chk({tag, " ex_pc"},        bus.ex_pc,                 e.pc);
    chk({tag, " reg_write"},    {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
    chk({tag, " mem_read"},     {31'd0, bus.ex_mem_read},  {31'd0, e.mr});
    chk({tag, " mem_write"},    {31'd0, bus.ex_mem_write}, {31'd0, e.mw});
  endtask

  vec_t vec[17];
  fw_t  none;
  id_t  rinst;
  exp_t bub;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    none  = fw(0, 0, 0);
    bub   = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rinst = instr(1, 32'h50, 1, 32'h11, 2, 32'h22, 1, 0, 0, 3, 17'h1, 1, 0, 0);

    // MEM forward, MEM-over-WB priority, WB forward, store with immediate
    vec[0]  = '{instr(1, 32'h100, 5, 32'h1, 6, 32'h3, 1, 0, 0, 8, 17'h1, 1, 0, 0), 0,
                none, fw(1, 5, 32'h10), none, ex(0, 1, 32'h10, 32'h3, 32'h3, 17'h1, 8, 32'h100, 1, 0, 0)};
    vec[1]  = '{instr(1, 32'h104, 5, 32'h1, 6, 32'h3, 1, 0, 0, 8, 17'h1, 1, 0, 0), 0,
                none, fw(1, 5, 32'h10), fw(1, 5, 32'h99), ex(0, 1, 32'h10, 32'h3, 32'h3, 17'h1, 8, 32'h104, 1, 0, 0)};
    vec[2]  = '{instr(1, 32'h108, 5, 32'h1, 6, 32'h3, 1, 0, 0, 9, 17'h4, 1, 0, 0), 0,
                none, none, fw(1, 5, 32'h99), ex(0, 1, 32'h99, 32'h3, 32'h3, 17'h4, 9, 32'h108, 1, 0, 0)};
    vec[3]  = '{instr(1, 32'h10C, 2, 32'h1000, 9, 32'h0, 1, 32'h40, 1, 0, 17'h2, 0, 0, 1), 0,
                none, none, fw(1, 9, 32'hDEADBEEF),
                ex(0, 1, 32'h1000, 32'h40, 32'hDEADBEEF, 17'h2, 0, 32'h10C, 0, 0, 1)};
    // Load to x7, dependent rs2 stalls once, then picks up the value from WB
    vec[4]  = '{instr(1, 32'h110, 2, 32'h2000, 0, 0, 0, 32'h4, 1, 7, 17'h1, 1, 1, 0), 0,
                none, none, none, ex(0, 1, 32'h2000, 32'h4, 32'h0, 17'h1, 7, 32'h110, 1, 1, 0)};
    vec[5]  = '{instr(1, 32'h114, 1, 32'h5, 7, 32'h0, 1, 0, 0, 10, 17'h1, 1, 0, 0), 0,
                none, fw(1, 7, 32'hABCD), none, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vec[6]  = '{instr(1, 32'h114, 1, 32'h5, 7, 32'h0, 1, 0, 0, 10, 17'h1, 1, 0, 0), 0,
                none, none, fw(1, 7, 32'h77), ex(0, 1, 32'h5, 32'h77, 32'h77, 17'h1, 10, 32'h114, 1, 0, 0)};
    // Flush while a hazard is present, then an empty ID slot
    vec[7]  = '{instr(1, 32'h118, 0, 0, 0, 0, 0, 32'h8, 1, 7, 17'h1, 1, 1, 0), 0,
                none, none, none, ex(0, 1, 32'h0, 32'h8, 32'h0, 17'h1, 7, 32'h118, 1, 1, 0)};
    vec[8]  = '{instr(1, 32'h11C, 7, 32'h0, 0, 0, 0, 0, 0, 11, 17'h1, 1, 0, 0), 1,
                none, none, none, bub};
    vec[9]  = '{instr(0, 32'h120, 1, 32'h1, 2, 32'h2, 1, 0, 0, 12, 17'h1, 1, 0, 0), 0,
                none, none, none, bub};
    // rs2 match without id_uses_rs2 is not a hazard; rs1 match is
    vec[10] = '{instr(1, 32'h124, 0, 0, 0, 0, 0, 32'h10, 1, 3, 17'h1, 1, 1, 0), 0,
                none, none, none, ex(0, 1, 32'h0, 32'h10, 32'h0, 17'h1, 3, 32'h124, 1, 1, 0)};
    vec[11] = '{instr(1, 32'h128, 4, 32'h4, 3, 32'h9, 0, 0, 0, 13, 17'h1, 1, 0, 0), 0,
                none, none, none, ex(0, 1, 32'h4, 32'h9, 32'h9, 17'h1, 13, 32'h128, 1, 0, 0)};
    vec[12] = '{instr(1, 32'h12C, 0, 0, 0, 0, 0, 32'h14, 1, 3, 17'h1, 1, 1, 0), 0,
                none, none, none, ex(0, 1, 32'h0, 32'h14, 32'h0, 17'h1, 3, 32'h12C, 1, 1, 0)};
    vec[13] = '{instr(1, 32'h130, 3, 32'h0, 0, 0, 0, 0, 0, 14, 17'h1, 1, 0, 0), 0,
                none, none, none, bub};
    vec[13].e.stall = 1'b1;
    // WB capture bypass on rs1 with stale register-file data
    vec[14] = '{instr(1, 32'h130, 3, 32'h0, 0, 0, 0, 0, 0, 14, 17'h1, 1, 0, 0), 0,
                fw(1, 3, 32'h1234), none, none, ex(0, 1, 32'h1234, 32'h0, 32'h0, 17'h1, 14, 32'h130, 1, 0, 0)};
    // x0 is never forwarded, at capture or in EX
    vec[15] = '{instr(1, 32'h134, 0, 32'h0, 0, 32'h0, 1, 0, 0, 15, 17'h1, 1, 0, 0), 0,
                fw(1, 0, 32'h77), fw(1, 0, 32'h55), fw(1, 0, 32'h66),
                ex(0, 1, 32'h0, 32'h0, 32'h0, 17'h1, 15, 32'h134, 1, 0, 0)};
    vec[16] = '{instr(1, 32'h138, 1, 32'h8, 6, 32'h0, 1, 0, 0, 16, 17'h8, 1, 0, 0), 0,
                fw(1, 6, 32'hCAFE), none, none, ex(0, 1, 32'h8, 32'hCAFE, 32'hCAFE, 17'h8, 16, 32'h138, 1, 0, 0)};

    // Reset held two cycles with a valid instruction presented
    drive_id(rinst, 0);
    drive_fw(none, none);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("reset stall_id", {31'd0, bus.stall_id}, 32'd0);
      chk_ex("reset", bub);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_ex("first after reset", ex(0, 1, 32'h11, 32'h22, 32'h22, 17'h1, 3, 32'h50, 1, 0, 0));

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_id(vec[i].id, vec[i].flush);
      drive_fw(none, vec[i].cwb);
      #2;
      chk($sformatf("v%0d stall_id", i), {31'd0, bus.stall_id}, {31'd0, vec[i].e.stall});
      @(posedge clk); #1;
      drive_fw(vec[i].omem, vec[i].owb);
      #1;
      chk_ex($sformatf("v%0d", i), vec[i].e);
    end

    // Reset overrides a pending load-use stall: EX holds a load, ID depends on it
    @(negedge clk);
    drive_fw(none, none);
    drive_id(instr(1, 32'h200, 0, 0, 0, 0, 0, 32'h4, 1, 9, 17'h1, 1, 1, 0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    drive_id(instr(1, 32'h204, 9, 32'h0, 0, 0, 0, 0, 0, 5, 17'h1, 1, 0, 0), 0);
    #2;
    chk("pre-reset stall_id", {31'd0, bus.stall_id}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_ex("reset over stall", bub);
    chk("after reset stall_id", {31'd0, bus.stall_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_ex("after reset release", ex(0, 1, 32'h0, 32'h0, 32'h0, 17'h1, 5, 32'h204, 1, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
